// File: rtl/bit_reverse_accel_deadlock_reporter.sv
// Deadlock reporter for the bit_reverse_accel monitors.
// Declares a deadlock once THRESH consecutive blocked cycles are seen.
// It then holds a sticky report until a clear pulse arrives:
// source mask, detection timestamp, stall length and detection count.
module bit_reverse_accel_deadlock_reporter #(
  parameter int N_MON  = 2,
  parameter int CNT_W  = 32,
  parameter int THRESH = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_MON-1:0]   block_in,
  input  logic               enable,
  input  logic               clear,
  output logic               deadlock,
  output logic [N_MON-1:0]   deadlock_src,
  output logic [CNT_W-1:0]   det_timestamp,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [7:0]         event_count
);

  typedef enum logic [1:0] {IDLE, COUNTING, DETECTED} state_t;

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic [N_MON-1:0]   src_acc_q, src_acc_d;
  logic [CNT_W-1:0]   ts_q, ts_d;
  logic               deadlock_q, deadlock_d;
  logic [N_MON-1:0]   det_src_q, det_src_d;
  logic [CNT_W-1:0]   det_ts_q, det_ts_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               stall_run_q, stall_run_d;  // detected run still blocking
  logic [7:0]         event_q, event_d;
  logic               any_blk;
  logic               detect;

  assign any_blk = |block_in;

  // Next-state logic: run filter, detection edge, stall growth, clear override.
  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    src_acc_d   = src_acc_q;
    ts_d        = ts_q + ONE_C;
    deadlock_d  = deadlock_q;
    det_src_d   = det_src_q;
    det_ts_d    = det_ts_q;
    stall_d     = stall_q;
    stall_run_d = stall_run_q;
    event_d     = event_q;
    detect      = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && any_blk) begin
          run_cnt_d = ONE_C;
          src_acc_d = block_in;
          if (THRESH == 1) detect = 1'b1;
          else             state_d = COUNTING;
        end
      end
      COUNTING: begin
        if (!any_blk || !enable) begin
          run_cnt_d = '0;
          src_acc_d = '0;
          state_d   = IDLE;
        end else begin
          run_cnt_d = run_cnt_q + ONE_C;
          src_acc_d = src_acc_q | block_in;
          if (run_cnt_q + ONE_C == THRESH_C) detect = 1'b1;
        end
      end
      DETECTED: begin
        // Stall length only tracks the run that caused detection; once it
        // breaks, later blocking leaves the report untouched.
        if (stall_run_q) begin
          if (any_blk) begin
            if (stall_q != '1) stall_d = stall_q + ONE_C;
          end else begin
            stall_run_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (detect) begin
      state_d     = DETECTED;
      deadlock_d  = 1'b1;
      det_src_d   = src_acc_q | block_in;
      det_ts_d    = ts_q;
      stall_d     = THRESH_C;
      stall_run_d = 1'b1;
      event_d     = (event_q == 8'hFF) ? event_q : event_q + 8'd1;
    end

    // Clear wins over everything, including a detection on the same edge.
    if (clear) begin
      state_d     = IDLE;
      run_cnt_d   = '0;
      src_acc_d   = '0;
      deadlock_d  = 1'b0;
      det_src_d   = '0;
      det_ts_d    = '0;
      stall_d     = '0;
      stall_run_d = 1'b0;
      event_d     = event_q;
    end
  end

  // State and report registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      run_cnt_q   <= '0;
      src_acc_q   <= '0;
      ts_q        <= '0;
      deadlock_q  <= 1'b0;
      det_src_q   <= '0;
      det_ts_q    <= '0;
      stall_q     <= '0;
      stall_run_q <= 1'b0;
      event_q     <= '0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      src_acc_q   <= src_acc_d;
      ts_q        <= ts_d;
      deadlock_q  <= deadlock_d;
      det_src_q   <= det_src_d;
      det_ts_q    <= det_ts_d;
      stall_q     <= stall_d;
      stall_run_q <= stall_run_d;
      event_q     <= event_d;
    end
  end

  assign deadlock      = deadlock_q;
  assign deadlock_src  = det_src_q;
  assign det_timestamp = det_ts_q;
  assign stall_cycles  = stall_q;
  assign event_count   = event_q;

endmodule

// File: tb/tb_bit_reverse_accel_deadlock_reporter.sv
// Directed bench for the deadlock reporter: three instances cover
// THRESH=4 (main behaviour), THRESH=1, and a 4-bit counter variant.
module tb_bit_reverse_accel_deadlock_reporter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // THRESH=4, CNT_W=32
  logic [1:0]  blk_a = '0;
  logic        en_a = 1'b1, clr_a = 1'b0;
  logic        dl_a;
  logic [1:0]  src_a;
  logic [31:0] ts_a, st_a;
  logic [7:0]  ev_a;

  // THRESH=1, CNT_W=32
  logic [1:0]  blk_b = '0;
  logic        en_b = 1'b1, clr_b = 1'b0;
  logic        dl_b;
  logic [1:0]  src_b;
  logic [31:0] ts_b, st_b;
  logic [7:0]  ev_b;

  // THRESH=3, CNT_W=4
  logic [1:0]  blk_c = '0;
  logic        en_c = 1'b1, clr_c = 1'b0;
  logic        dl_c;
  logic [1:0]  src_c;
  logic [3:0]  ts_c, st_c;
  logic [7:0]  ev_c;

  int n_chk  = 0;
  int n_fail = 0;

  bit_reverse_accel_deadlock_reporter #(.N_MON(2), .CNT_W(32), .THRESH(4)) u_a (
    .clock(clock), .reset(reset), .block_in(blk_a), .enable(en_a), .clear(clr_a),
    .deadlock(dl_a), .deadlock_src(src_a), .det_timestamp(ts_a),
    .stall_cycles(st_a), .event_count(ev_a));

  bit_reverse_accel_deadlock_reporter #(.N_MON(2), .CNT_W(32), .THRESH(1)) u_b (
    .clock(clock), .reset(reset), .block_in(blk_b), .enable(en_b), .clear(clr_b),
    .deadlock(dl_b), .deadlock_src(src_b), .det_timestamp(ts_b),
    .stall_cycles(st_b), .event_count(ev_b));

  bit_reverse_accel_deadlock_reporter #(.N_MON(2), .CNT_W(4), .THRESH(3)) u_c (
    .clock(clock), .reset(reset), .block_in(blk_c), .enable(en_c), .clear(clr_c),
    .deadlock(dl_c), .deadlock_src(src_c), .det_timestamp(ts_c),
    .stall_cycles(st_c), .event_count(ev_c));

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %-24s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // After this, the next rising edge samples ts == 0.
  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_deadlock", {31'd0, dl_a}, 32'd0);
    chk("rst_src",      {30'd0, src_a}, 32'd0);
    chk("rst_ts",       ts_a, 32'd0);
    chk("rst_stall",    st_a, 32'd0);
    chk("rst_events",   {24'd0, ev_a}, 32'd0);

    // Basic detect: blocked on edges sampling ts 10..13.
    step(10);
    blk_a = 2'b01;
    step(3);
    chk("basic_pre_deadlock", {31'd0, dl_a}, 32'd0);
    step(1);
    blk_a = 2'b00;
    chk("basic_deadlock", {31'd0, dl_a}, 32'd1);
    chk("basic_ts",       ts_a, 32'd13);
    chk("basic_src",      {30'd0, src_a}, 32'd1);
    chk("basic_stall",    st_a, 32'd4);
    chk("basic_events",   {24'd0, ev_a}, 32'd1);
    step(3);
    chk("basic_sticky",   {31'd0, dl_a}, 32'd1);

    // Clear wipes the report but keeps the event count.
    clr_a = 1'b1; step(1); clr_a = 1'b0;
    chk("clr_deadlock", {31'd0, dl_a}, 32'd0);
    chk("clr_src",      {30'd0, src_a}, 32'd0);
    chk("clr_ts",       ts_a, 32'd0);
    chk("clr_stall",    st_a, 32'd0);
    chk("clr_events",   {24'd0, ev_a}, 32'd1);

    // Glitch filter: 3 blocked, 1 free, 3 blocked.
    do_reset();
    blk_a = 2'b10; step(3);
    blk_a = 2'b00; step(1);
    blk_a = 2'b10; step(3);
    blk_a = 2'b00; step(2);
    chk("glitch_deadlock", {31'd0, dl_a}, 32'd0);
    chk("glitch_events",   {24'd0, ev_a}, 32'd0);

    // Source accumulation and stall growth.
    blk_a = 2'b01; step(2);
    blk_a = 2'b10; step(2);
    chk("acc_deadlock", {31'd0, dl_a}, 32'd1);
    chk("acc_stall4",   st_a, 32'd4);
    step(6);
    chk("acc_stall10",  st_a, 32'd10);
    chk("acc_src",      {30'd0, src_a}, 32'd3);
    blk_a = 2'b00; step(1);
    blk_a = 2'b10; step(3);
    chk("acc_frozen",   st_a, 32'd10);
    chk("acc_src_keep", {30'd0, src_a}, 32'd3);
    chk("acc_events",   {24'd0, ev_a}, 32'd1);
    blk_a = 2'b00;

    // Clear priority over a simultaneous detection.
    clr_a = 1'b1; step(1); clr_a = 1'b0;
    blk_a = 2'b01; step(3);
    clr_a = 1'b1; step(1); clr_a = 1'b0;
    chk("prio_deadlock", {31'd0, dl_a}, 32'd0);
    chk("prio_events",   {24'd0, ev_a}, 32'd1);
    step(3);
    chk("prio_pre_det",  {31'd0, dl_a}, 32'd0);
    step(1);
    chk("prio_redetect", {31'd0, dl_a}, 32'd1);
    chk("prio_events2",  {24'd0, ev_a}, 32'd2);
    chk("prio_stall",    st_a, 32'd4);
    blk_a = 2'b00;

    // Enable low blocks detection.
    clr_a = 1'b1; step(1); clr_a = 1'b0;
    en_a = 1'b0; blk_a = 2'b01; step(20);
    chk("en_deadlock", {31'd0, dl_a}, 32'd0);
    chk("en_events",   {24'd0, ev_a}, 32'd2);
    blk_a = 2'b00; en_a = 1'b1;

    // Mid-run reset restores everything, event count included.
    blk_a = 2'b11; step(2);
    do_reset();
    blk_a = 2'b00;
    chk("mrst_events", {24'd0, ev_a}, 32'd0);
    step(3);
    chk("mrst_deadlock", {31'd0, dl_a}, 32'd0);

    // THRESH=1: a single blocked cycle detects.
    blk_b = 2'b10; step(1);
    blk_b = 2'b00;
    chk("t1_deadlock", {31'd0, dl_b}, 32'd1);
    chk("t1_stall",    st_b, 32'd1);
    chk("t1_src",      {30'd0, src_b}, 32'd2);
    chk("t1_events",   {24'd0, ev_b}, 32'd1);
    step(2);
    chk("t1_stall_frz", st_b, 32'd1);

    // 4-bit counters: ts wraps 15->0, detection at ts=17 mod 16 = 1.
    do_reset();
    step(15);
    blk_c = 2'b01; step(3);
    chk("w_deadlock", {31'd0, dl_c}, 32'd1);
    chk("w_ts_wrap",  {28'd0, ts_c}, 32'd1);
    chk("w_stall3",   {28'd0, st_c}, 32'd3);
    step(40);
    chk("w_stall_sat", {28'd0, st_c}, 32'd15);
    blk_c = 2'b00;

    // Event count saturation after 300 detect/clear cycles.
    for (int k = 0; k < 300; k++) begin
      clr_c = 1'b1; blk_c = 2'b00; step(1);
      clr_c = 1'b0; blk_c = 2'b01; step(3);
    end
    blk_c = 2'b00;
    chk("sat_events",   {24'd0, ev_c}, 32'd255);
    chk("sat_deadlock", {31'd0, dl_c}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
